// File: rtl/clut_pkg.sv
//------------------------------------------------------------------------------
// Module  : clut_pkg
// Brief   : Shared CLUT types, default geometry and bytes-per-colour helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clut_pkg;

  localparam int CLUT_COLRW = 12;
  localparam int CLUT_CIDXW = 4;
  localparam int CLUT_BYTEW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } clut_ld_state_t;

  function automatic int clut_bpc(input int colrw, input int bytew);
    return (colrw + bytew - 1) / bytew;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clut_loader.sv
//------------------------------------------------------------------------------
// Module  : clut_loader
// Brief   : Assembles big-endian colour words from a byte stream and writes
//           them to consecutive CLUT indices.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clut_loader
  import clut_pkg::*;
#(
  parameter int COLRW = CLUT_COLRW,
  parameter int CIDXW = CLUT_CIDXW,
  parameter int BYTEW = CLUT_BYTEW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CIDXW-1:0] start_idx,
  input  logic [CIDXW:0]   count,
  input  logic [BYTEW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             we,
  output logic [CIDXW-1:0] cidx_write,
  output logic [COLRW-1:0] colr_in,
  output logic             busy,
  output logic             done
);

  localparam int C_BPC   = clut_bpc(COLRW, BYTEW);
  localparam int C_WORDW = C_BPC * BYTEW;
  localparam int C_BCW   = $clog2(C_BPC + 1);
  localparam int C_CNTW  = CIDXW + 1;

  localparam logic [C_CNTW-1:0] C_DEPTH = C_CNTW'(2 ** CIDXW);
  localparam logic [C_CNTW-1:0] C_ONE   = C_CNTW'(1);
  localparam logic [C_BCW-1:0]  C_LAST  = C_BCW'(C_BPC - 1);

  clut_ld_state_t     r_state;
  clut_ld_state_t     w_state_nx;
  logic [CIDXW-1:0]   r_idx;
  logic [C_CNTW-1:0]  r_rem;
  logic [C_BCW-1:0]   r_bcnt;
  logic [C_WORDW-1:0] r_shift;
  logic               r_we;
  logic               r_done;
  logic               r_busy;
  logic               r_in_ready;
  logic [CIDXW-1:0]   r_cidx;
  logic [COLRW-1:0]   r_colr;

  logic               w_xfer;
  logic               w_last_byte;
  logic [C_WORDW-1:0] w_word;
  logic [C_CNTW-1:0]  w_count_cl;
  logic               w_we_nx;
  logic               w_done_nx;
  logic               w_busy_nx;
  logic               w_ready_nx;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_last_byte = w_xfer && (r_bcnt == C_LAST);
  // Shifting the whole word left lets old bytes fall off the top for any BPC.
  assign w_word      = (r_shift << BYTEW) | C_WORDW'(in_data);
  assign w_count_cl  = (count > C_DEPTH) ? C_DEPTH : count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nx = (w_count_cl == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          w_state_nx = IDLE;
        end else if (w_last_byte) begin
          w_state_nx = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = (r_rem == C_ONE) ? DONE : LOAD;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Output values are decoded from the next state so they land in flops.
  always_comb begin
    w_we_nx    = 1'b0;
    w_done_nx  = 1'b0;
    w_busy_nx  = 1'b0;
    w_ready_nx = 1'b0;
    case (w_state_nx)
      LOAD:    begin w_busy_nx = 1'b1; w_ready_nx = 1'b1; end
      WRITE:   begin w_busy_nx = 1'b1; w_we_nx    = 1'b1; end
      DONE:    begin w_busy_nx = 1'b1; w_done_nx  = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_rem      <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
      r_cidx     <= '0;
      r_colr     <= '0;
    end else begin
      r_we       <= w_we_nx;
      r_done     <= w_done_nx;
      r_busy     <= w_busy_nx;
      r_in_ready <= w_ready_nx;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_idx   <= start_idx;
            r_rem   <= w_count_cl;
            r_bcnt  <= '0;
            r_shift <= '0;
          end
        end
        LOAD: begin
          if (w_xfer && !abort) begin
            r_shift <= w_word;
            r_bcnt  <= r_bcnt + C_BCW'(1);
            if (w_last_byte) begin
              r_cidx <= r_idx;
              r_colr <= w_word[COLRW-1:0];
            end
          end
        end
        WRITE: begin
          r_idx  <= r_idx + CIDXW'(1);
          r_rem  <= r_rem - C_ONE;
          r_bcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign we         = r_we;
  assign cidx_write = r_cidx;
  assign colr_in    = r_colr;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_clut_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_clut_loader
// Brief   : Self-checking bench for clut_loader with a cycle-level reference.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clut_loader;

  localparam int COLRW = 12;
  localparam int CIDXW = 4;
  localparam int BYTEW = 8;
  localparam int BPC   = (COLRW + BYTEW - 1) / BYTEW;
  localparam int DEPTH = 2 ** CIDXW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort, in_valid;
  logic [CIDXW-1:0] start_idx;
  logic [CIDXW:0]   count;
  logic [BYTEW-1:0] in_data;
  logic             in_ready, we, busy, done;
  logic [CIDXW-1:0] cidx_write;
  logic [COLRW-1:0] colr_in;

  int checks = 0;
  int errors = 0;

  clut_loader #(.COLRW(COLRW), .CIDXW(CIDXW), .BYTEW(BYTEW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_idx(start_idx), .count(count), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .we(we),
    .cidx_write(cidx_write), .colr_in(colr_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: what the outputs must read after each clock edge.
  logic             m_we = 0, m_done = 0, m_busy = 0, m_rdy = 0;
  logic [CIDXW-1:0] m_cidx = 0, m_idx = 0;
  logic [COLRW-1:0] m_colr = 0;
  int               m_word = 0, m_left = 0, m_nb = 0;
  logic             nwe, ndn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_we = 0; m_done = 0; m_busy = 0; m_rdy = 0;
      m_cidx = 0; m_colr = 0; m_idx = 0; m_word = 0; m_left = 0; m_nb = 0;
    end else begin
      nwe = 0; ndn = 0;
      if (m_we) begin
        if (abort) begin m_busy = 0; m_rdy = 0; end
        else begin
          m_idx = m_idx + 1; m_left--; m_nb = 0;
          if (m_left == 0) begin ndn = 1; m_rdy = 0; end else m_rdy = 1;
        end
      end else if (m_done) begin
        m_busy = 0; m_rdy = 0;
      end else if (!m_busy) begin
        if (start && !abort) begin
          m_idx = start_idx; m_left = (count > DEPTH) ? DEPTH : int'(count);
          m_nb = 0; m_word = 0; m_busy = 1;
          if (m_left == 0) begin ndn = 1; m_rdy = 0; end else m_rdy = 1;
        end
      end else if (m_rdy) begin
        if (abort) begin m_busy = 0; m_rdy = 0; end
        else if (in_valid) begin
          m_word = ((m_word << BYTEW) | int'(in_data)) & ((1 << (BPC * BYTEW)) - 1);
          m_nb++;
          if (m_nb == BPC) begin
            nwe = 1; m_rdy = 0; m_cidx = m_idx; m_colr = m_word[COLRW-1:0];
          end
        end
      end
      m_we = nwe; m_done = ndn;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  logic [15:0] wq[$];
  int          ndone = 0;
  logic        saw_ready = 0;

  always @(negedge clk) begin
    chk("we", 32'(we), 32'(m_we));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("cidx_write", 32'(cidx_write), 32'(m_cidx));
    chk("colr_in", 32'(colr_in), 32'(m_colr));
    if (we) wq.push_back({cidx_write, colr_in});
    if (done) ndone++;
    if (in_ready) saw_ready = 1;
  end

  task automatic start_load(input logic [CIDXW-1:0] si, input logic [CIDXW:0] c);
    @(negedge clk); start = 1; start_idx = si; count = c;
    @(negedge clk); start = 0;
  endtask

  task automatic send_byte(input logic [BYTEW-1:0] b, input int gap);
    int n;
    n = 0;
    in_data = b; in_valid = 1;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_byte timeout got=no_ready want=ready");
    end
    @(negedge clk); in_valid = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout got=busy want=idle");
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_we"}, 32'(we), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_rdy"}, 32'(in_ready), 0);
    chk({nm, "_cidx"}, 32'(cidx_write), 0);
    chk({nm, "_colr"}, 32'(colr_in), 0);
  endtask

  logic [BYTEW-1:0] bytes[32];
  int d0, ncl, ng;

  initial begin
    rst_n = 0; start = 0; abort = 0; in_valid = 0;
    start_idx = 0; count = 0; in_data = 0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    #2 rst_n = 1;

    // Basic load
    wq.delete(); d0 = ndone;
    start_load(0, 2);
    send_byte(8'h0F, 0); send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
    wait_idle();
    chk("basic_nwr", wq.size(), 2);
    if (wq.size() == 2) begin chk("basic_w0", wq[0], 16'h0FA5); chk("basic_w1", wq[1], 16'h1123); end
    chk("basic_done", ndone - d0, 1);

    // Wrap from the top index
    wq.delete();
    start_load(15, 2);
    send_byte(8'h0A, 0); send_byte(8'hBC, 0); send_byte(8'h0D, 0); send_byte(8'hEF, 0);
    wait_idle();
    chk("wrap_nwr", wq.size(), 2);
    if (wq.size() == 2) begin chk("wrap_w0", wq[0], 16'hFABC); chk("wrap_w1", wq[1], 16'h0DEF); end

    // Stalls between bytes and truncated high nibble
    wq.delete();
    start_load(0, 2);
    send_byte(8'hFF, 3); send_byte(8'hA5, 3); send_byte(8'h01, 3); send_byte(8'h23, 3);
    wait_idle();
    chk("stall_nwr", wq.size(), 2);
    if (wq.size() == 2) begin chk("stall_w0", wq[0], 16'h0FA5); chk("stall_w1", wq[1], 16'h1123); end

    // Zero count
    wq.delete(); d0 = ndone; saw_ready = 0;
    start_load(3, 0);
    wait_idle();
    chk("zero_nwr", wq.size(), 0);
    chk("zero_done", ndone - d0, 1);
    chk("zero_ready", 32'(saw_ready), 0);

    // Clamped full-table load from index 5
    wq.delete();
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
    start_load(5, 31);
    for (int i = 0; i < 32; i++) send_byte(bytes[i], 0);
    wait_idle();
    chk("clamp_nwr", wq.size(), 16);
    if (wq.size() == 16)
      for (int k = 0; k < 16; k++)
        chk("clamp_w", wq[k], {4'((5 + k) % 16), bytes[2*k][3:0], bytes[2*k+1]});

    // Abort mid-colour, then a clean single-colour load
    wq.delete(); d0 = ndone;
    start_load(2, 3);
    send_byte(8'h12, 0);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("abort_nwr", wq.size(), 0);
    chk("abort_done", ndone - d0, 0);
    start_load(9, 1);
    send_byte(8'h07, 0); send_byte(8'h77, 0);
    wait_idle();
    chk("after_abort_nwr", wq.size(), 1);
    if (wq.size() == 1) chk("after_abort_w", wq[0], 16'h9777);

    // start together with abort in IDLE
    @(negedge clk); start = 1; abort = 1; count = 3; start_idx = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("start_abort_busy", 32'(busy), 0);

    // Ignored start during an active load
    wq.delete();
    start_load(0, 2);
    send_byte(8'h0F, 0);
    start = 1; start_idx = 9; count = 5;
    @(negedge clk); start = 0;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
    wait_idle();
    chk("ign_nwr", wq.size(), 2);
    if (wq.size() == 2) begin chk("ign_w0", wq[0], 16'h0FA5); chk("ign_w1", wq[1], 16'h1123); end

    // Reset mid-LOAD after one write landed
    wq.delete();
    start_load(6, 4);
    send_byte(8'h03, 0); send_byte(8'h45, 0); send_byte(8'h06, 0);
    #2 rst_n = 0;
    #1 chk_zero_outs("midrst");
    @(negedge clk); #2 rst_n = 1;
    repeat (4) @(negedge clk);
    chk("midrst_nwr", wq.size(), 1);

    // Randomised loads with random gaps
    for (int t = 0; t < 8; t++) begin
      wq.delete();
      ncl = $urandom_range(0, 20);
      start_load(4'($urandom_range(0, 15)), 5'(ncl));
      if (ncl > DEPTH) ncl = DEPTH;
      for (int i = 0; i < ncl * BPC; i++) begin
        ng = $urandom_range(0, 2);
        send_byte(8'($urandom), ng);
      end
      wait_idle();
      chk("rand_nwr", wq.size(), ncl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clut_loader.md
Name: clut_loader

Overview:
- Writer for the colour lookup table: accepts a byte stream (UART, SPI flash or a CPU FIFO) and assembles big-endian colour words.
- Drives the CLUT write port with one `we` pulse per colour, at consecutive indices from a programmable start index.
- Sits in the display clock domain, next to the palette RAM. Its outputs connect directly to the CLUT `we`/`cidx_write`/`colr_in`.

Parameters:
- COLRW, 12, colour width in bits (matches CLUT).
- CIDXW, 4, colour index width in bits (CLUT depth = 2**CIDXW).
- BYTEW, 8, input stream byte width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin load; sampled only in IDLE.
- abort  in  1  cancel load; return to IDLE, no done.
- start_idx  in  CIDXW  first CLUT index to write.
- count  in  CIDXW+1  number of colours; 0..2**CIDXW.
- in_data  in  BYTEW  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- we  out  1  CLUT write enable, one-cycle pulse.
- cidx_write  out  CIDXW  CLUT write index.
- colr_in  out  COLRW  CLUT write colour.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at load completion.

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, internal index/remaining/byte counter/shift register cleared.
- Byte transfer: occurs when in_valid && in_ready.
- Bytes per colour: BPC = ceil(COLRW/BYTEW); 2 at defaults. The first byte is most significant. The word is BPC*BYTEW bits, and colr_in takes its low COLRW bits; upper bits are discarded.
- FSM states: IDLE, LOAD, WRITE, DONE. All outputs are registered.
  - IDLE, start=1:
    - Latch start_idx into idx.
    - Latch min(count, 2**CIDXW) into remaining.
    - Clear the byte counter.
    - Next state is LOAD, or DONE if count==0.
  - IDLE, start=0: stay in IDLE.
  - LOAD: in_ready=1. Each transfer shifts the byte into the word and increments the byte counter. The transfer of byte BPC goes to WRITE. in_valid gaps stall without side effects.
  - WRITE:
    - Single cycle: we=1, cidx_write=idx, colr_in=assembled word, in_ready=0.
    - idx <= idx+1, wrapping modulo 2**CIDXW; remaining decrements; the byte counter clears.
    - Next state is DONE if remaining was 1, else LOAD.
  - DONE: done=1 for one cycle, then IDLE.
- Latency and throughput:
  - we is asserted the cycle after the last byte's transfer.
  - done is asserted the cycle after the final we.
  - Peak throughput is one colour per BPC+1 cycles.
- Hold values: cidx_write and colr_in hold their last written values when we=0. The CLUT ignores them.
- start while busy: ignored.
- abort (any non-IDLE state): next state is IDLE.
  - A partially assembled colour is discarded and no we is issued. No done pulse.
  - abort has priority over a simultaneous transfer or WRITE.
  - Writes already completed remain in the CLUT.
- start and abort together in IDLE: abort wins and the loader stays idle.
- count > 2**CIDXW: clamped to 2**CIDXW. A full-table load from start_idx≠0 wraps and covers every index exactly once.
- in_ready is 0 in IDLE, WRITE and DONE. The upstream must hold the byte until it is accepted.
- Reset mid-operation: immediate return to the reset state, with no further we.

Decomposition:
- Shared package clut_pkg:
  - state enum type `clut_ld_state_t` {IDLE, LOAD, WRITE, DONE}.
  - Function computing BPC from COLRW and BYTEW.
  - Defaults COLRW/CIDXW reused by clut_simple instances.
- Sub-module: none. Byte assembly is a shift register plus counter and stays inline; total RTL is about 150 lines.

Test Plan (COLRW=12, CIDXW=4):
- Basic load: start_idx=0, count=2, bytes 0x0F,0xA5,0x01,0x23 back-to-back -> we at idx 0 with 0xFA5, then we at idx 1 with 0x123. done is pulsed the cycle after the second we; busy then goes low.
- Wrap: start_idx=15, count=2, bytes 0x0A,0xBC,0x0D,0xEF -> we at idx 15 with 0xABC, then idx 0 with 0xDEF. No write to idx 1.
- Stalls and truncation: same as the basic load, but in_valid is low for 3 cycles between every byte, and the first byte is 0xFF -> colr_in=0xFA5 (high nibble discarded). we count is exactly 2 and no we occurs mid-colour.
- Zero count and clamping: count=0 -> done the cycle after start, no we, in_ready never 1. count=31 with start_idx=5 -> exactly 16 writes, indices 5..15,0..4.
- Abort: abort after the first byte of colour 1 of 3 -> no we for that colour, busy=0 next cycle, no done. A following start with count=1 and bytes 0x07,0x77 writes 0x777 normally.
- Reset and ignored start: assert rst_n=0 mid-LOAD -> all outputs 0 immediately. start pulsed during an active load -> no change to idx or remaining; the load completes with the original count.
